linear_layer_sequencer: RTL and testbench

LINEAR_LAYER_SEQUENCER -- requirements
Module: linear_layer_sequencer

---
 rtl/linear_layer_sequencer.sv | 122 ++++++++++++
 tb/tb_linear_layer_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/linear_layer_sequencer.sv
// Fixed-point (Q15.16) matrix-vector sequencer: walks a weight register file
// row by row, accumulates weight*x products per row, and streams out one
// saturated result per row over a valid/ready handshake.
module linear_layer_sequencer #(
    parameter int N_ROWS    = 20,
    parameter int N_COLS    = 20,
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 16,
    parameter int ACC_W     = 56
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [4:0]        row_addr,
    output logic [4:0]        col_addr,
    input  logic [DATA_W-1:0] weight_in,
    output logic [4:0]        x_addr,
    input  logic [DATA_W-1:0] x_in,
    output logic              y_valid,
    input  logic              y_ready,
    output logic [DATA_W-1:0] y_data,
    output logic [4:0]        y_index
);

    localparam int PROD_W  = 2 * DATA_W;
    localparam int SHIFT_W = PROD_W - FRAC_BITS;

    typedef enum logic [1:0] {IDLE, MAC, OUT, DONE} state_t;

    state_t                   state;
    logic [4:0]               row;
    logic [4:0]               col;
    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  acc_next;
    logic [DATA_W-1:0]        sat_y;
    logic                     unused_frac;

    assign row_addr = row;
    assign col_addr = col;
    assign x_addr   = col;

    // Product term (floor shift by the fraction width), wrapping accumulate, and saturation of the running sum
    always_comb begin
        product  = $signed(weight_in) * $signed(x_in);
        term     = {{(ACC_W - SHIFT_W){product[PROD_W-1]}}, product[PROD_W-1:FRAC_BITS]};
        acc_next = acc + term;
        if ((&acc_next[ACC_W-1:DATA_W-1]) || (~|acc_next[ACC_W-1:DATA_W-1])) begin
            sat_y = acc_next[DATA_W-1:0];
        end else if (acc_next[ACC_W-1]) begin
            sat_y = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_y = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    // Fraction bits below the binary point are discarded by the floor shift
    assign unused_frac = ^product[FRAC_BITS-1:0];

    // Sequencing FSM with registered status and output-stream signals; the saturated
    // result is captured on the last MAC edge so it is stable for the whole OUT state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            acc     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            y_valid <= 1'b0;
            y_data  <= '0;
            y_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= MAC;
                        row   <= '0;
                        col   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (col == 5'(N_COLS - 1)) begin
                        col     <= '0;
                        y_data  <= sat_y;
                        y_index <= row;
                        y_valid <= 1'b1;
                        state   <= OUT;
                    end else begin
                        col <= col + 5'd1;
                    end
                end
                OUT: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        acc     <= '0;
                        if (row == 5'(N_ROWS - 1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            row   <= row + 5'd1;
                            state <= MAC;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_linear_layer_sequencer.sv
// Bench for linear_layer_sequencer: a cycle-level behavioural model (row/column
// counters plus a plain-arithmetic dot product) checked against the DUT on
// every negative clock edge, with literal expectations for the directed cases.
module tb_linear_layer_sequencer;

    localparam int N_ROWS = 20;
    localparam int N_COLS = 20;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  row_addr;
    logic [4:0]  col_addr;
    logic [31:0] weight_in;
    logic [4:0]  x_addr;
    logic [31:0] x_in;
    logic        y_valid;
    logic        y_ready;
    logic [31:0] y_data;
    logic [4:0]  y_index;

    logic [31:0] w_mem [N_ROWS][N_COLS];
    logic [31:0] x_mem [N_COLS];
    logic [31:0] exp_y [N_ROWS];
    logic [31:0] got_y [N_ROWS];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int ready_mode = 0;

    // model state
    int m_busy = 0;
    int m_done = 0;
    int m_row = 0;
    int m_k = 0;

    assign weight_in = (row_addr < 5'(N_ROWS) && col_addr < 5'(N_COLS)) ? w_mem[row_addr][col_addr] : 32'h0;
    assign x_in      = (x_addr < 5'(N_COLS)) ? x_mem[x_addr] : 32'h0;

    linear_layer_sequencer #(
        .N_ROWS(N_ROWS), .N_COLS(N_COLS), .DATA_W(32), .FRAC_BITS(16), .ACC_W(56)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .row_addr(row_addr), .col_addr(col_addr), .weight_in(weight_in),
        .x_addr(x_addr), .x_in(x_in), .y_valid(y_valid), .y_ready(y_ready),
        .y_data(y_data), .y_index(y_index)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference row result: exact dot product of floor-shifted products, wrapped to 56 bits, saturated to 32
    function automatic logic [31:0] model_y(input int r);
        longint acc;
        longint p;
        acc = 0;
        for (int j = 0; j < N_COLS; j++) begin
            p = longint'($signed(w_mem[r][j])) * longint'($signed(x_mem[j]));
            acc = acc + (p >>> 16);
        end
        acc = (acc <<< 8) >>> 8;
        if (acc > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
        if (acc < -64'sh8000_0000) return 32'h8000_0000;
        return acc[31:0];
    endfunction

    // y_ready driver: 0 = always ready, 1 = random back-pressure, 2 = held low
    initial begin
        y_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: y_ready = 1'b1;
                1: y_ready = ($urandom_range(0, 3) != 0);
                default: y_ready = 1'b0;
            endcase
        end
    end

    // Compare process: check every output against the model, then advance the model
    initial begin
        int exp_col;
        int exp_valid;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy = 0; m_done = 0; m_row = 0; m_k = 0;
            end
            exp_valid = (m_busy != 0 && m_done == 0 && m_k == N_COLS) ? 1 : 0;
            exp_col   = (m_busy != 0 && m_done == 0 && m_k < N_COLS) ? m_k : 0;
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("y_valid", 64'(y_valid), 64'(exp_valid));
            check("row_addr", 64'(row_addr), 64'(m_row));
            check("col_addr", 64'(col_addr), 64'(exp_col));
            check("x_addr", 64'(x_addr), 64'(exp_col));
            if (exp_valid != 0) begin
                check("y_data", 64'(y_data), 64'(exp_y[m_row]));
                check("y_index", 64'(y_index), 64'(m_row));
            end
            if (rst) begin
                check("rst_y_data", 64'(y_data), 64'h0);
                check("rst_y_index", 64'(y_index), 64'h0);
            end
            if (done && !rst) begin
                done_cnt++;
                done_cyc = cyc - t0;
            end
            if (y_valid && y_ready && !rst && y_index < 5'(N_ROWS)) got_y[y_index] = y_data;

            if (rst) begin
                // stay idle
            end else if (m_done != 0) begin
                m_done = 0; m_busy = 0;
            end else if (m_busy == 0) begin
                if (start) begin
                    m_busy = 1; m_row = 0; m_k = 0; t0 = cyc;
                    for (int r = 0; r < N_ROWS; r++) exp_y[r] = model_y(r);
                end
            end else if (m_k < N_COLS) begin
                m_k++;
            end else if (y_ready) begin
                if (m_row == N_ROWS - 1) m_done = 1;
                else begin
                    m_row++; m_k = 0;
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int prev;
        prev = done_cnt;
        for (int i = 0; i < 3000 && done_cnt == prev; i++) @(posedge clk);
        if (done_cnt == prev) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: got no done, required done within 3000 cycles");
        end
    endtask

    task automatic run_pass();
        for (int r = 0; r < N_ROWS; r++) got_y[r] = 32'hDEAD_BEEF;
        pulse_start();
        wait_done();
    endtask

    task automatic fill_identity();
        for (int r = 0; r < N_ROWS; r++) begin
            for (int c = 0; c < N_COLS; c++) w_mem[r][c] = (r == c) ? 32'h0001_0000 : 32'h0;
        end
        for (int c = 0; c < N_COLS; c++) x_mem[c] = c << 16;
    endtask

    task automatic fill_const(input logic [31:0] w, input logic [31:0] x);
        for (int r = 0; r < N_ROWS; r++) begin
            for (int c = 0; c < N_COLS; c++) w_mem[r][c] = w;
        end
        for (int c = 0; c < N_COLS; c++) x_mem[c] = x;
    endtask

    task automatic fill_random(input int wide);
        for (int r = 0; r < N_ROWS; r++) begin
            for (int c = 0; c < N_COLS; c++)
                w_mem[r][c] = (wide != 0) ? $urandom : ($urandom_range(0, 524288) - 262144);
        end
        for (int c = 0; c < N_COLS; c++)
            x_mem[c] = (wide != 0) ? $urandom : ($urandom_range(0, 524288) - 262144);
    endtask

    initial begin
        int cnt;
        int prev;
        rst = 1'b1;
        start = 1'b0;
        fill_identity();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // identity pass
        fill_identity();
        ready_mode = 0;
        run_pass();
        check("ident_done_cycle", 64'(done_cyc), 64'd421);
        check("ident_model_y7", 64'(exp_y[7]), 64'h0007_0000);
        for (int i = 0; i < N_ROWS; i += 6) check("ident_y", 64'(got_y[i]), 64'(i << 16));
        check("ident_y19", 64'(got_y[19]), 64'h0013_0000);

        // all ones / all minus ones
        fill_const(32'h0001_0000, 32'h0001_0000);
        run_pass();
        check("ones_model", 64'(exp_y[10]), 64'h0014_0000);
        check("ones_y0", 64'(got_y[0]), 64'h0014_0000);
        check("ones_y19", 64'(got_y[19]), 64'h0014_0000);
        fill_const(32'hFFFF_0000, 32'h0001_0000);
        run_pass();
        check("neg_y5", 64'(got_y[5]), 64'hFFEC_0000);

        // saturation both ways
        fill_const(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_pass();
        check("satmax_y0", 64'(got_y[0]), 64'h7FFF_FFFF);
        fill_const(32'h8000_0000, 32'h7FFF_FFFF);
        run_pass();
        check("satmin_y19", 64'(got_y[19]), 64'h8000_0000);

        // five-cycle stall on row 3
        fill_identity();
        for (int r = 0; r < N_ROWS; r++) got_y[r] = 32'hDEAD_BEEF;
        pulse_start();
        for (int i = 0; i < 200 && row_addr != 5'd3; i++) @(posedge clk);
        #1 ready_mode = 2;
        cnt = 0;
        for (int i = 0; i < 200 && cnt < 5; i++) begin
            @(negedge clk);
            if (y_valid) cnt++;
        end
        check("stall_cycles_seen", 64'(cnt), 64'd5);
        ready_mode = 0;
        wait_done();
        check("stall_done_cycle", 64'(done_cyc), 64'd426);
        check("stall_y3", 64'(got_y[3]), 64'h0003_0000);

        // randomized passes with random back-pressure
        for (int p = 0; p < 4; p++) begin
            fill_random(p % 2);
            ready_mode = 1;
            run_pass();
        end
        ready_mode = 0;

        // start re-pulsed mid-pass is ignored
        fill_identity();
        for (int r = 0; r < N_ROWS; r++) got_y[r] = 32'hDEAD_BEEF;
        pulse_start();
        repeat (48) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        check("restart_done_cycle", 64'(done_cyc), 64'd421);
        check("restart_y12", 64'(got_y[12]), 64'h000C_0000);

        // reset mid-pass discards it; a new start completes normally
        prev = done_cnt;
        pulse_start();
        repeat (98) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        check("rst_no_done", 64'(done_cnt), 64'(prev));
        check("rst_busy", 64'(busy), 64'h0);
        fill_const(32'hFFFF_0000, 32'h0001_0000);
        run_pass();
        check("post_rst_done_cycle", 64'(done_cyc), 64'd421);
        check("post_rst_y9", 64'(got_y[9]), 64'hFFEC_0000);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
